decode_stage_pipe: RTL and testbench

Registered, flow-controlled RV32I/RV64I decode stage sitting between fetch and execute. Decodes one instruction per cycle into the execute/memory/write-back control bundle, sign-extended immediate and register indices. Inserts a one-cycle bubble on load-use hazards and tightens illegal-instruction detection per func3/func7. The M extension is enabled by parameter, and the stage keeps saturating stall and invalid counters.

---
 rtl/decode_pkg.sv | 79 +++++++
 rtl/imm_gen.sv | 35 +++
 rtl/decode_stage_pipe.sv | 185 ++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Purpose : shared opcodes, memory-type encodings, immediate formats and the decode bundle.
// Latency : n/a (declarations and a pure function only).
// Backpr. : n/a.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [2:0] LD_B    = 3'b000;
  localparam logic [2:0] LD_H    = 3'b001;
  localparam logic [2:0] LD_W    = 3'b010;
  localparam logic [2:0] LD_BU   = 3'b011;
  localparam logic [2:0] LD_HU   = 3'b100;
  localparam logic [2:0] LD_NONE = 3'b111;

  localparam logic [1:0] ST_B    = 2'b00;
  localparam logic [1:0] ST_H    = 2'b01;
  localparam logic [1:0] ST_W    = 2'b10;
  localparam logic [1:0] ST_NONE = 2'b11;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Everything the output register carries apart from the XLEN-wide pc/imm.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] func3;
    logic       alu_src;
    logic       mem_write;
    logic [2:0] ld_type;
    logic [1:0] st_type;
    logic       wb_load;
    logic       wb_reg;
    logic       invalid;
    logic       m_type;
    logic       branch;
    logic       jump;
  } dec_t;

  localparam dec_t DEC_RST = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, func3: 3'd0,
    alu_src: 1'b0, mem_write: 1'b0,
    ld_type: LD_NONE, st_type: ST_NONE,
    wb_load: 1'b0, wb_reg: 1'b0, invalid: 1'b0,
    m_type: 1'b0, branch: 1'b0, jump: 1'b0
  };

  // RISC-V load func3 -> downstream load-type code (LBU/LHU are renumbered).
  function automatic logic [2:0] ld_type_of(input logic [2:0] f3);
    case (f3)
      3'b000:  ld_type_of = LD_B;
      3'b001:  ld_type_of = LD_H;
      3'b010:  ld_type_of = LD_W;
      3'b100:  ld_type_of = LD_BU;
      3'b101:  ld_type_of = LD_HU;
      default: ld_type_of = LD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Purpose : builds the sign-extended immediate for the I/S/B/U/J formats (0 for none).
// Latency : combinational.
// Backpr. : none; pure function of its inputs.
// Ports   : instr[31:0] instruction word, fmt immediate format, imm[XLEN-1:0] result.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opcode;

  // Opcode bits are never part of an immediate.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Every format is already sign-correct at 32 bits; widen for RV64.
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Purpose : registered RV32I/RV64I(+M) decode stage with load-use bubble and saturating counters.
// Latency : 1 cycle; input accepted at edge N is on the outputs after edge N.
// Backpr. : in_ready = (!out_valid | out_ready) & !hz & !flush; outputs hold while stalled.
// Ports   : clk/rst (sync, active-high); fetch side flush, in_valid/in_ready, in_instr, in_pc;
//           execute side out_valid/out_ready, out_pc, out_imm, out_rs1/rs2/rd, out_func3,
//           control bundle, stall_count and invalid_count.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_func3,
  output logic             ex_alu_src,
  output logic             mem_write,
  output logic [2:0]       mem_load_type,
  output logic [1:0]       mem_store_type,
  output logic             wb_load,
  output logic             wb_reg_file,
  output logic             invalid_inst,
  output logic             m_type_inst,
  output logic             branch_inst,
  output logic             jump_inst,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] invalid_count
);

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic is_r, is_m, is_imm, is_load, is_store, is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic known, bad, uses_rs1, uses_rs2, hz, accept;
  imm_fmt_e        fmt;
  dec_t            dec_new, dec_d, dec_q;
  logic [XLEN-1:0] imm_new, imm_d, imm_q, pc_d, pc_q;
  logic            out_valid_d, out_valid_q;
  logic [CNT_W-1:0] stall_d, stall_q, inv_d, inv_q;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  // Class decode. OP with func7 0000001 is an M op whatever ENABLE_M says;
  // legality is judged separately below.
  always_comb begin
    is_r     = (opcode == OP_R) && ((f7 == F7_BASE) || (f7 == F7_ALT));
    is_m     = (opcode == OP_R) && (f7 == F7_MUL);
    is_imm   = (opcode == OP_IMM);
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    is_lui   = (opcode == OP_LUI);
    is_auipc = (opcode == OP_AUIPC);
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR);
    is_br    = (opcode == OP_BRANCH);
    // An OP opcode with an unlisted func7 falls out of every class here.
    known    = is_r | is_m | is_imm | is_load | is_store | is_lui | is_auipc
             | is_jal | is_jalr | is_br;
    bad      = !known
             | (is_load  & ((f3 == 3'b011) | (f3[2:1] == 2'b11)))
             | (is_store & (f3 >= 3'b011))
             | (is_br    & (f3[2:1] == 2'b01))
             | (is_jalr  & (f3 != 3'b000))
             | (is_m     & !ENABLE_M);
    uses_rs1 = is_r | is_m | is_imm | is_load | is_store | is_jalr | is_br;
    uses_rs2 = is_r | is_m | is_store | is_br;

    fmt = IMM_NONE;
    if (is_imm | is_load | is_jalr) fmt = IMM_I;
    else if (is_store)              fmt = IMM_S;
    else if (is_br)                 fmt = IMM_B;
    else if (is_lui | is_auipc)     fmt = IMM_U;
    else if (is_jal)                fmt = IMM_J;

    dec_new           = DEC_RST;
    dec_new.rs1       = in_instr[19:15];
    dec_new.rs2       = in_instr[24:20];
    dec_new.rd        = in_instr[11:7];
    dec_new.func3     = f3;
    dec_new.alu_src   = is_imm | is_load | is_store | is_lui | is_auipc | is_jalr;
    dec_new.jump      = is_jal | is_jalr;
    dec_new.branch    = is_br;
    dec_new.m_type    = is_m & ENABLE_M;
    dec_new.invalid   = bad;
    // Side-effecting controls are suppressed for anything illegal.
    dec_new.wb_reg    = !bad & (is_r | is_m | is_imm | is_load | is_lui | is_auipc | is_jal | is_jalr);
    dec_new.wb_load   = !bad & is_load;
    dec_new.mem_write = !bad & is_store;
    dec_new.ld_type   = (!bad & is_load)  ? ld_type_of(f3) : LD_NONE;
    dec_new.st_type   = (!bad & is_store) ? f3[1:0]        : ST_NONE;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt),
    .imm   (imm_new)
  );

  // Load-use: the held load's destination is read by the incoming instruction.
  assign hz = out_valid_q & dec_q.wb_load & (dec_q.rd != 5'd0) & in_valid
            & ((uses_rs1 & (in_instr[19:15] == dec_q.rd))
             | (uses_rs2 & (in_instr[24:20] == dec_q.rd)));

  assign in_ready = (!out_valid_q | out_ready) & !hz & !flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    dec_d       = dec_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    stall_d     = stall_q;
    inv_d       = inv_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      dec_d       = dec_new;
      imm_d       = imm_new;
      pc_d        = in_pc;
    end else if (out_ready) begin
      // Either the load-use bubble or a plain drain with nothing arriving.
      out_valid_d = 1'b0;
    end

    if (!flush && hz && out_ready && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
    if (accept && dec_new.invalid && (inv_q != '1))
      inv_d = inv_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dec_q       <= DEC_RST;
      imm_q       <= '0;
      pc_q        <= '0;
      stall_q     <= '0;
      inv_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      stall_q     <= stall_d;
      inv_q       <= inv_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = pc_q;
  assign out_imm        = imm_q;
  assign out_rs1        = dec_q.rs1;
  assign out_rs2        = dec_q.rs2;
  assign out_rd         = dec_q.rd;
  assign out_func3      = dec_q.func3;
  assign ex_alu_src     = dec_q.alu_src;
  assign mem_write      = dec_q.mem_write;
  assign mem_load_type  = dec_q.ld_type;
  assign mem_store_type = dec_q.st_type;
  assign wb_load        = dec_q.wb_load;
  assign wb_reg_file    = dec_q.wb_reg;
  assign invalid_inst   = dec_q.invalid;
  assign m_type_inst    = dec_q.m_type;
  assign branch_inst    = dec_q.branch;
  assign jump_inst      = dec_q.jump;
  assign stall_count    = stall_q;
  assign invalid_count  = inv_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Purpose : self-checking bench for decode_stage_pipe (ENABLE_M=1 and ENABLE_M=0 side by side).
// Latency : n/a.
// Backpr. : drives out_ready directly, including long stalls.
module tb_decode_stage_pipe;

  logic clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        o_in_ready, o_out_valid, o_alu_src, o_mem_write, o_wb_load, o_wb_reg, o_invalid, o_m_type, o_branch, o_jump;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [2:0]  o_f3, o_ld;
  logic [1:0]  o_st;
  logic [15:0] o_stall, o_inv;

  logic        n_in_ready, n_out_valid, n_alu_src, n_mem_write, n_wb_load, n_wb_reg, n_invalid, n_m_type, n_branch, n_jump;
  logic [31:0] n_pc, n_imm;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  logic [2:0]  n_f3, n_ld;
  logic [1:0]  n_st;
  logic [15:0] n_stall, n_inv;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what the output register should hold.
  logic        m_valid, m_has, last_rdy;
  logic [31:0] m_instr, m_pc;
  int          m_stall, m_inv, m_inv_nm;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3, ld;
    logic [1:0] st;
    logic alu_src, mem_write, wb_load, wb_reg, invalid, m_type, branch, jump, u1, u2;
    longint imm;
  } ref_t;

  decode_stage_pipe #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(o_out_valid), .out_ready(out_ready),
    .out_pc(o_pc), .out_imm(o_imm), .out_rs1(o_rs1), .out_rs2(o_rs2), .out_rd(o_rd),
    .out_func3(o_f3), .ex_alu_src(o_alu_src), .mem_write(o_mem_write), .mem_load_type(o_ld),
    .mem_store_type(o_st), .wb_load(o_wb_load), .wb_reg_file(o_wb_reg), .invalid_inst(o_invalid),
    .m_type_inst(o_m_type), .branch_inst(o_branch), .jump_inst(o_jump),
    .stall_count(o_stall), .invalid_count(o_inv));

  decode_stage_pipe #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(16)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_pc), .out_imm(n_imm), .out_rs1(n_rs1), .out_rs2(n_rs2), .out_rd(n_rd),
    .out_func3(n_f3), .ex_alu_src(n_alu_src), .mem_write(n_mem_write), .mem_load_type(n_ld),
    .mem_store_type(n_st), .wb_load(n_wb_load), .wb_reg_file(n_wb_reg), .invalid_inst(n_invalid),
    .m_type_inst(n_m_type), .branch_inst(n_branch), .jump_inst(n_jump),
    .stall_count(n_stall), .invalid_count(n_inv));

  always #5 clk = ~clk;

  function automatic ref_t reset_ref();
    ref_t r;
    r = '{rs1: 0, rs2: 0, rd: 0, f3: 0, ld: 3'd7, st: 2'd3, alu_src: 0, mem_write: 0,
          wb_load: 0, wb_reg: 0, invalid: 0, m_type: 0, branch: 0, jump: 0, u1: 0, u2: 0, imm: 0};
    return r;
  endfunction

  // Decoding straight from the ISA tables, immediates by weighted bit sums.
  function automatic ref_t ref_decode(input logic [31:0] w, input bit en_m);
    ref_t r;
    int op, f3, f7;
    bit rc, mc, ia, ldc, stc, lui, aui, jal, jalr, br, bad;
    int ldmap[8] = '{0, 1, 2, 7, 3, 4, 7, 7};
    r = reset_ref();
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    rc = (op == 51) && (f7 == 0 || f7 == 32);
    mc = (op == 51) && (f7 == 1);
    ia = (op == 19); ldc = (op == 3); stc = (op == 35); lui = (op == 55);
    aui = (op == 23); jal = (op == 111); jalr = (op == 103); br = (op == 99);
    bad = !(rc || mc || ia || ldc || stc || lui || aui || jal || jalr || br);
    if (ldc && (f3 == 3 || f3 == 6 || f3 == 7)) bad = 1;
    if (stc && f3 >= 3) bad = 1;
    if (br && (f3 == 2 || f3 == 3)) bad = 1;
    if (jalr && f3 != 0) bad = 1;
    if (mc && !en_m) bad = 1;
    r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7]; r.f3 = w[14:12];
    r.alu_src = ia || ldc || stc || lui || aui || jalr;
    r.jump = jal || jalr; r.branch = br; r.m_type = mc && en_m; r.invalid = bad;
    r.wb_reg = !bad && (rc || mc || ia || ldc || lui || aui || jal || jalr);
    r.wb_load = !bad && ldc; r.mem_write = !bad && stc;
    r.ld = (!bad && ldc) ? 3'(ldmap[f3]) : 3'd7;
    r.st = (!bad && stc) ? 2'(f3) : 2'd3;
    r.u1 = rc || mc || ia || ldc || stc || jalr || br;
    r.u2 = rc || mc || stc || br;
    if (ia || ldc || jalr)
      r.imm = longint'(w[30:20]) - (w[31] ? 2048 : 0);
    else if (stc)
      r.imm = longint'(w[30:25]) * 32 + longint'(w[11:7]) - (w[31] ? 2048 : 0);
    else if (br)
      r.imm = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
    else if (lui || aui)
      r.imm = longint'(w[30:12]) * 4096 - (w[31] ? 64'sd2147483648 : 0);
    else if (jal)
      r.imm = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
    else
      r.imm = 0;
    return r;
  endfunction

  function automatic ref_t held_ref(input bit en_m);
    return m_has ? ref_decode(m_instr, en_m) : reset_ref();
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ref_t e, en;
    logic [31:0] eimm;
    e = held_ref(1'b1); en = held_ref(1'b0);
    eimm = e.imm[31:0];
    chk("out_valid", 64'(o_out_valid), 64'(m_valid));
    chk("out_pc", 64'(o_pc), m_has ? 64'(m_pc) : 64'd0);
    chk("out_imm", 64'(o_imm), 64'(eimm));
    chk("out_rs1", 64'(o_rs1), 64'(e.rs1));
    chk("out_rs2", 64'(o_rs2), 64'(e.rs2));
    chk("out_rd", 64'(o_rd), 64'(e.rd));
    chk("out_func3", 64'(o_f3), 64'(e.f3));
    chk("ex_alu_src", 64'(o_alu_src), 64'(e.alu_src));
    chk("mem_write", 64'(o_mem_write), 64'(e.mem_write));
    chk("mem_load_type", 64'(o_ld), 64'(e.ld));
    chk("mem_store_type", 64'(o_st), 64'(e.st));
    chk("wb_load", 64'(o_wb_load), 64'(e.wb_load));
    chk("wb_reg_file", 64'(o_wb_reg), 64'(e.wb_reg));
    chk("invalid_inst", 64'(o_invalid), 64'(e.invalid));
    chk("m_type_inst", 64'(o_m_type), 64'(e.m_type));
    chk("branch_inst", 64'(o_branch), 64'(e.branch));
    chk("jump_inst", 64'(o_jump), 64'(e.jump));
    chk("stall_count", 64'(o_stall), 64'(m_stall));
    chk("invalid_count", 64'(o_inv), 64'(m_inv));
    chk("nm_out_valid", 64'(n_out_valid), 64'(m_valid));
    chk("nm_invalid_inst", 64'(n_invalid), 64'(en.invalid));
    chk("nm_wb_reg_file", 64'(n_wb_reg), 64'(en.wb_reg));
    chk("nm_invalid_count", 64'(n_inv), 64'(m_inv_nm));
  endtask

  // One clock of stimulus: drive, check in_ready, advance the model, check outputs.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    ref_t e, n;
    logic hz_m, ird;
    in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    e = held_ref(1'b1); n = ref_decode(w, 1'b1);
    hz_m = m_valid && e.wb_load && (e.rd != 0) && v &&
           ((n.u1 && n.rs1 == e.rd) || (n.u2 && n.rs2 == e.rd));
    ird = (!m_valid || ordy) && !hz_m && !fl;
    last_rdy = o_in_ready;
    chk("in_ready", 64'(o_in_ready), 64'(ird));
    chk("nm_in_ready", 64'(n_in_ready), 64'(ird));
    if (rst) begin
      m_valid = 0; m_has = 0; m_instr = 0; m_pc = 0; m_stall = 0; m_inv = 0; m_inv_nm = 0;
    end else if (fl) begin
      m_valid = 0;
    end else if (v && ird) begin
      m_valid = 1; m_has = 1; m_instr = w; m_pc = pc;
      if (n.invalid && m_inv < 65535) m_inv++;
      if (ref_decode(w, 1'b0).invalid && m_inv_nm < 65535) m_inv_nm++;
    end else if (ordy) begin
      m_valid = 0;
      if (hz_m && m_stall < 65535) m_stall++;
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    case (k)
      0:  begin w[6:0] = 7'h33; w[31:25] = 7'h00; end
      1:  begin w[6:0] = 7'h33; w[31:25] = 7'h20; end
      2:  begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
      3:  w[6:0] = 7'h13;
      4:  w[6:0] = 7'h03;
      5:  w[6:0] = 7'h23;
      6:  w[6:0] = 7'h37;
      7:  w[6:0] = 7'h17;
      8:  w[6:0] = 7'h6f;
      9:  begin w[6:0] = 7'h67; w[14:12] = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0; end
      10: w[6:0] = 7'h63;
      default: w[6:0] = 7'($urandom);
    endcase
    return w;
  endfunction

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_ADD2 = 32'h00128333;
  localparam logic [31:0] I_MUL  = 32'h023100B3;
  localparam logic [31:0] I_SH   = 32'h00209223;
  localparam logic [31:0] I_SBAD = 32'h0020B223;

  initial begin
    clk = 0; rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
    m_valid = 0; m_has = 0; m_instr = 0; m_pc = 0; m_stall = 0; m_inv = 0; m_inv_nm = 0;
    last_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check_outputs();

    // ADD x3,x1,x2
    step(1'b1, I_ADD, 32'h100, 1'b1, 1'b0);
    chk("t1_rd", 64'(o_rd), 64'd3);
    chk("t1_rs1", 64'(o_rs1), 64'd1);
    chk("t1_rs2", 64'(o_rs2), 64'd2);
    chk("t1_wb_reg", 64'(o_wb_reg), 64'd1);

    // LW x5,8(x1) then dependent ADD x6,x5,x1
    do_reset();
    step(1'b1, I_LW, 32'h200, 1'b1, 1'b0);
    chk("t2_ld_type", 64'(o_ld), 64'd2);
    chk("t2_imm", 64'(o_imm), 64'd8);
    step(1'b1, I_ADD2, 32'h204, 1'b1, 1'b0);
    chk("t2_hz_in_ready", 64'(last_rdy), 64'd0);
    chk("t2_bubble_valid", 64'(o_out_valid), 64'd0);
    chk("t2_stall_count", 64'(o_stall), 64'd1);
    step(1'b1, I_ADD2, 32'h204, 1'b1, 1'b0);
    chk("t2_add_rd", 64'(o_rd), 64'd6);
    chk("t2_add_valid", 64'(o_out_valid), 64'd1);

    // MUL x1,x2,x3 with and without M
    do_reset();
    step(1'b1, I_MUL, 32'h300, 1'b1, 1'b0);
    chk("t3_m_type", 64'(o_m_type), 64'd1);
    chk("t3_m_invalid", 64'(o_invalid), 64'd0);
    chk("t3_nm_invalid", 64'(n_invalid), 64'd1);
    chk("t3_nm_wb_reg", 64'(n_wb_reg), 64'd0);
    chk("t3_nm_inv_count", 64'(n_inv), 64'd1);

    // SH and its illegal func3=011 twin
    step(1'b1, I_SH, 32'h304, 1'b1, 1'b0);
    chk("t4_mem_write", 64'(o_mem_write), 64'd1);
    chk("t4_st_type", 64'(o_st), 64'd1);
    chk("t4_imm", 64'(o_imm), 64'd4);
    step(1'b1, I_SBAD, 32'h308, 1'b1, 1'b0);
    chk("t4_bad_invalid", 64'(o_invalid), 64'd1);
    chk("t4_bad_mem_write", 64'(o_mem_write), 64'd0);
    chk("t4_bad_st_type", 64'(o_st), 64'd3);

    // Downstream stall for 3 cycles, then release
    do_reset();
    step(1'b1, I_ADD, 32'h400, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, I_SH, 32'h404, 1'b0, 1'b0);
      chk("t5_stall_in_ready", 64'(last_rdy), 64'd0);
      chk("t5_hold_pc", 64'(o_pc), 64'h400);
    end
    step(1'b1, I_SH, 32'h404, 1'b1, 1'b0);
    chk("t5_next_pc", 64'(o_pc), 64'h404);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with a held instruction and a valid incoming one
    step(1'b1, I_ADD, 32'h500, 1'b0, 1'b0);
    step(1'b1, I_LW, 32'h504, 1'b0, 1'b1);
    chk("t6_flush_valid", 64'(o_out_valid), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t6_dropped_pc", 64'(o_pc), 64'h500);

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, rand_instr(), $urandom,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    // Reset mid-stream
    rst = 1;
    step(1'b1, I_LW, 32'h600, 1'b1, 1'b0);
    rst = 0;
    chk("t6_rst_stall", 64'(o_stall), 64'd0);
    chk("t6_rst_inv", 64'(o_inv), 64'd0);
    chk("t6_rst_ld", 64'(o_ld), 64'd7);
    step(1'b1, I_ADD, 32'h604, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
